// File: rtl/blue_seq_ctrl_if.sv
// Instruction-memory read port and ALU operand/result bundle between the
// Blue sequencer (master) and the memory/ALU side (slave).
interface blue_seq_ctrl_if #(
   parameter int AW = 8
);
   logic          imem_en;
   logic [AW-1:0] imem_addr;
   logic [17:0]   imem_rdata;
   logic [15:0]   alu_ra;
   logic [15:0]   alu_rb;
   logic [15:0]   alu_ins;
   logic [15:0]   alu_ra_out;
   logic [15:0]   alu_rb_out;

   modport master (
      output imem_en, imem_addr, alu_ra, alu_rb, alu_ins,
      input  imem_rdata, alu_ra_out, alu_rb_out
   );

   modport slave (
      input  imem_en, imem_addr, alu_ra, alu_rb, alu_ins,
      output imem_rdata, alu_ra_out, alu_rb_out
   );
endinterface

// File: rtl/blue_seq_ctrl.sv
// Fetch/execute sequencer for the Blue ALU: owns RA/RB and the PC, fetches
// 18-bit words, runs LDA/LDB/HALT itself and hands class-00 words to the ALU.
module blue_seq_ctrl #(
   parameter int AW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   blue_seq_ctrl_if.master bus,
   output logic            busy,
   output logic            done,
   output logic            overrun,
   output logic [15:0]     ra_q,
   output logic [15:0]     rb_q,
   output logic [15:0]     instr_count
);
   typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

   localparam logic [AW-1:0] PC_LAST = '1;
   localparam logic [AW-1:0] PC_ONE  = AW'(1);

   state_t        state_reg, state_next;
   logic [AW-1:0] pc_reg, pc_next;
   logic [15:0]   ra_reg, ra_next;
   logic [15:0]   rb_reg, rb_next;
   logic [15:0]   cnt_reg, cnt_next;
   logic          ovr_reg, ovr_next;

   logic [1:0]    ins_class;
   logic [15:0]   payload;

   assign ins_class = bus.imem_rdata[17:16];
   assign payload   = bus.imem_rdata[15:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         pc_reg    <= '0;
         ra_reg    <= '0;
         rb_reg    <= '0;
         cnt_reg   <= '0;
         ovr_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         ra_reg    <= ra_next;
         rb_reg    <= rb_next;
         cnt_reg   <= cnt_next;
         ovr_reg   <= ovr_next;
      end
   end

   // Kept apart from the next-state logic: the ALU results fed back into
   // ra_next/rb_next are combinational functions of this payload.
   assign bus.alu_ins = (state_reg == EXEC && ins_class == 2'b00) ? payload : 16'h0000;

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      ra_next    = ra_reg;
      rb_next    = rb_reg;
      cnt_next   = cnt_reg;
      ovr_next   = ovr_reg;
      busy       = 1'b0;
      done       = 1'b0;
      bus.imem_en = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = FETCH;
               pc_next    = '0;
               cnt_next   = '0;
               ovr_next   = 1'b0;
            end
         end
         FETCH: begin
            busy        = 1'b1;
            bus.imem_en = 1'b1;
            state_next  = EXEC;
         end
         EXEC: begin
            busy     = 1'b1;
            cnt_next = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;
            unique case (ins_class)
               2'b00: begin
                  ra_next = bus.alu_ra_out;
                  rb_next = bus.alu_rb_out;
               end
               2'b01:   ra_next = payload;
               2'b10:   rb_next = payload;
               default: ;
            endcase
            // The last address still executes; the PC never wraps back to 0.
            if (ins_class == 2'b11) begin
               state_next = DONE;
            end else if (pc_reg == PC_LAST) begin
               ovr_next   = 1'b1;
               state_next = DONE;
            end else begin
               pc_next    = pc_reg + PC_ONE;
               state_next = FETCH;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.imem_addr = pc_reg;
   assign bus.alu_ra    = ra_reg;
   assign bus.alu_rb    = rb_reg;
   assign ra_q          = ra_reg;
   assign rb_q          = rb_reg;
   assign instr_count   = cnt_reg;
   assign overrun       = ovr_reg;
endmodule

// File: tb/tb_blue_seq_ctrl.sv
// Bench for blue_seq_ctrl: AW=8 and AW=2 instances, end-of-run results
// checked by done-triggered monitors against queued expectations.
module tb_blue_seq_ctrl;
   localparam logic [17:0] LDA  = 18'h10000;
   localparam logic [17:0] LDB  = 18'h20000;
   localparam logic [17:0] HALT = 18'h30000;

   typedef struct {
      logic [15:0] ra;
      logic [15:0] rb;
      logic [15:0] cnt;
      logic        ovr;
   } exp_t;

   logic clk;
   logic rst_n;
   logic start1, start2;
   logic busy1, done1, ovr1, busy2, done2, ovr2;
   logic [15:0] ra1, rb1, cnt1, ra2, rb2, cnt2;

   int checks = 0;
   int errors = 0;

   exp_t q1[$];
   exp_t q2[$];

   logic [17:0] mem1 [256];
   logic [17:0] mem2 [4];

   logic [15:0] ra_hist  [32];
   logic [15:0] rb_hist  [32];
   logic [15:0] ins_hist [32];

   blue_seq_ctrl_if #(.AW(8)) b1 ();
   blue_seq_ctrl_if #(.AW(2)) b2 ();

   blue_seq_ctrl #(.AW(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .bus(b1),
      .busy(busy1), .done(done1), .overrun(ovr1),
      .ra_q(ra1), .rb_q(rb1), .instr_count(cnt1)
   );

   blue_seq_ctrl #(.AW(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .bus(b2),
      .busy(busy2), .done(done2), .overrun(ovr2),
      .ra_q(ra2), .rb_q(rb2), .instr_count(cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous instruction memories
   always @(posedge clk) begin
      if (b1.imem_en) b1.imem_rdata <= mem1[b1.imem_addr];
      if (b2.imem_en) b2.imem_rdata <= mem2[b2.imem_addr];
   end

   // ALU model: 0x0001 = ADD into RA, 0x0002 = exchange, else pass-through
   always_comb begin
      b1.alu_ra_out = b1.alu_ra;
      b1.alu_rb_out = b1.alu_rb;
      case (b1.alu_ins)
         16'h0001: b1.alu_ra_out = b1.alu_ra + b1.alu_rb;
         16'h0002: begin
            b1.alu_ra_out = b1.alu_rb;
            b1.alu_rb_out = b1.alu_ra;
         end
         default: ;
      endcase
   end
   assign b2.alu_ra_out = b2.alu_ra;
   assign b2.alu_rb_out = b2.alu_rb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   // Monitors: every done pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (done1) begin
         if (q1.size() == 0) begin
            chk("d1_unexpected_done", 32'(done1), 32'd0);
         end else begin
            exp_t e;
            e = q1.pop_front();
            chk("d1_ra_q", 32'(ra1), 32'(e.ra));
            chk("d1_rb_q", 32'(rb1), 32'(e.rb));
            chk("d1_instr_count", 32'(cnt1), 32'(e.cnt));
            chk("d1_overrun", 32'(ovr1), 32'(e.ovr));
         end
      end
   end

   always @(negedge clk) begin
      if (done2) begin
         if (q2.size() == 0) begin
            chk("d2_unexpected_done", 32'(done2), 32'd0);
         end else begin
            exp_t e;
            e = q2.pop_front();
            chk("d2_ra_q", 32'(ra2), 32'(e.ra));
            chk("d2_rb_q", 32'(rb2), 32'(e.rb));
            chk("d2_instr_count", 32'(cnt2), 32'(e.cnt));
            chk("d2_overrun", 32'(ovr2), 32'(e.ovr));
         end
      end
   end

   // Start a dut1 run from IDLE; k counts cycles after the start edge.
   task automatic run1(input int budget, output int done_k, output int busy_n);
      done_k = 0;
      busy_n = 0;
      @(negedge clk);
      start1 = 1'b1;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         start1 = 1'b0;
         if (busy1) busy_n++;
         if (k < 32) begin
            ra_hist[k]  = ra1;
            rb_hist[k]  = rb1;
            ins_hist[k] = b1.alu_ins;
         end
         if (done1) begin
            done_k = k;
            break;
         end
      end
      if (done_k == 0) begin
         checks++;
         errors++;
         $display("FAIL d1_timeout actual=no done required=done within %0d cycles", budget);
      end
   endtask

   initial begin
      int dk, bn, dk1, dk2, ndone;
      bit got;

      for (int i = 0; i < 256; i++) mem1[i] = HALT;
      for (int i = 0; i < 4; i++) mem2[i] = HALT;
      rst_n  = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_done", 32'(done1), 32'd0);
      chk("rst_imem_en", 32'(b1.imem_en), 32'd0);
      chk("rst_alu_ins", 32'(b1.alu_ins), 32'd0);
      chk("rst_instr_count", 32'(cnt1), 32'd0);
      rst_n = 1'b1;

      // Main program: LDA 5, LDB 3, ADD, HALT
      mem1[0] = LDA | 18'h0005;
      mem1[1] = LDB | 18'h0003;
      mem1[2] = 18'h00001;
      mem1[3] = HALT;
      q1.push_back('{ra: 16'h0008, rb: 16'h0003, cnt: 16'd4, ovr: 1'b0});
      run1(40, dk, bn);
      chk("main_done_cycle", 32'(dk), 32'd9);
      chk("main_busy_cycles", 32'(bn), 32'd8);
      chk("main_alu_ins_c6", 32'(ins_hist[6]), 32'h0001);
      chk("main_alu_ra_c6", 32'(ra_hist[6]), 32'h0005);
      chk("main_alu_ins_lda_exec", 32'(ins_hist[2]), 32'h0000);
      chk("main_alu_ins_fetch", 32'(ins_hist[5]), 32'h0000);

      // Exchange through the ALU in a single EXEC
      mem1[0] = LDA | 18'h1234;
      mem1[1] = LDB | 18'hABCD;
      mem1[2] = 18'h00002;
      mem1[3] = HALT;
      q1.push_back('{ra: 16'hABCD, rb: 16'h1234, cnt: 16'd4, ovr: 1'b0});
      run1(40, dk, bn);
      chk("xchg_ra_before", 32'(ra_hist[6]), 32'h1234);
      chk("xchg_ra_after", 32'(ra_hist[7]), 32'hABCD);
      chk("xchg_rb_after", 32'(rb_hist[7]), 32'h1234);

      // Saturation: counter preloaded near the top, then 7 instructions
      for (int i = 0; i < 6; i++) mem1[i] = LDA | 18'(i + 1);
      mem1[6] = HALT;
      q1.push_back('{ra: 16'h0006, rb: 16'h1234, cnt: 16'hFFFF, ovr: 1'b0});
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      force dut1.cnt_reg = 16'hFFFD;
      @(negedge clk);
      release dut1.cnt_reg;
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done1) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL sat_timeout actual=no done required=done within 40 cycles");
      end

      // Reset asserted mid-EXEC: abort without a done pulse
      @(negedge clk);
      mem1[0] = LDA | 18'h0055;
      mem1[1] = HALT;
      start1  = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      @(negedge clk);
      chk("rst_mid_busy_before", 32'(busy1), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy_async", 32'(busy1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_mid_ra", 32'(ra1), 32'h0000);
      chk("rst_mid_rb", 32'(rb1), 32'h0000);
      chk("rst_mid_cnt", 32'(cnt1), 32'h0000);
      chk("rst_mid_pc", 32'(b1.imem_addr), 32'h00);
      repeat (6) @(negedge clk);
      chk("rst_mid_idle", 32'(busy1), 32'd0);

      // AW=2 overrun with ignored start pulses, then an accepted restart
      mem2[0] = LDA | 18'h0001;
      mem2[1] = LDA | 18'h0002;
      mem2[2] = LDA | 18'h0003;
      mem2[3] = LDA | 18'h0004;
      q2.push_back('{ra: 16'h0004, rb: 16'h0000, cnt: 16'd4, ovr: 1'b1});
      q2.push_back('{ra: 16'h0004, rb: 16'h0005, cnt: 16'd2, ovr: 1'b0});
      dk1 = 0;
      dk2 = 0;
      ndone = 0;
      @(negedge clk);
      start2 = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         start2 = (k == 1 || k == 2 || k == 9 || k == 10);
         if (k == 8) chk("ovr_not_yet", 32'(ovr2), 32'd0);
         if (k == 9) begin
            mem2[0] = LDB | 18'h0005;
            mem2[1] = HALT;
         end
         if (k == 11) begin
            chk("restart_ovr_clear", 32'(ovr2), 32'd0);
            chk("restart_cnt_clear", 32'(cnt2), 32'd0);
            chk("restart_ra_kept", 32'(ra2), 32'h0004);
            chk("restart_busy", 32'(busy2), 32'd1);
         end
         if (done2) begin
            ndone++;
            if (ndone == 1) dk1 = k;
            else dk2 = k;
         end
      end
      start2 = 1'b0;
      chk("ovr_done_cycle", 32'(dk1), 32'd9);
      chk("restart_done_cycle", 32'(dk2), 32'd15);
      chk("abuse_done_count", 32'(ndone), 32'd2);

      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("q2_drained", 32'(q2.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
